// File: rtl/lsu_mem_arbiter_if.sv
// LSU-to-memory channel bundle: per-consumer read/write request ports plus the single memory channel.
// The master modport is the surrounding core/memory; the slave modport is the arbiter.
interface lsu_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory channel among LSU ports, one transaction in flight; memory valid
// rises 1 cycle after a request is sampled, consumer ready follows mem ready by 1 cycle and holds until valid drops.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  localparam int IDW          = $clog2(NUM_CONSUMERS)
) (
  input  logic           clk,
  input  logic           reset,
  lsu_mem_arbiter_if.slave bus,
  output logic           busy,
  output logic [IDW-1:0] grant_id
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    WRITE_WAIT  = 3'd2,
    READ_RELAY  = 3'd3,
    WRITE_RELAY = 3'd4
  } state_t;

  localparam logic [IDW:0]   NC   = (IDW+1)'(NUM_CONSUMERS);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_CONSUMERS - 1);

  state_t                             state_q, state_d;
  logic [IDW-1:0]                     rr_q, rr_d, grant_d, pick, grant_nxt;
  logic [IDW:0]                       idx;
  logic                               found;
  logic                               rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [ADDR_BITS-1:0]               rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]               wr_data_q, wr_data_d;
  logic [NUM_CONSUMERS-1:0]           rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_id  <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_id  <= grant_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_id;
    rd_vld_d  = rd_vld_q;
    wr_vld_d  = wr_vld_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_rdy_d  = rd_rdy_q;
    wr_rdy_d  = wr_rdy_q;
    rd_data_d = rd_data_q;
    found     = 1'b0;
    pick      = '0;
    idx       = '0;
    grant_nxt = (grant_id == LAST) ? '0 : grant_id + 1'b1;

    // First requester at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx = {1'b0, rr_q} + (IDW+1)'(k);
      if (idx >= NC) idx = idx - NC;
      if (!found && (bus.consumer_read_valid[idx[IDW-1:0]] || bus.consumer_write_valid[idx[IDW-1:0]])) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          if (bus.consumer_read_valid[pick]) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = bus.consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            state_d   = READ_WAIT;
          end else begin
            wr_vld_d  = 1'b1;
            wr_addr_d = bus.consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
            wr_data_d = bus.consumer_write_data[pick*DATA_BITS +: DATA_BITS];
            state_d   = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (bus.mem_read_ready) begin
          rd_data_d[grant_id*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
          rd_vld_d           = 1'b0;
          rd_rdy_d[grant_id] = 1'b1;
          state_d            = READ_RELAY;
        end
      end
      WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          wr_vld_d           = 1'b0;
          wr_rdy_d[grant_id] = 1'b1;
          state_d            = WRITE_RELAY;
        end
      end
      READ_RELAY: begin
        if (!bus.consumer_read_valid[grant_id]) begin
          rd_rdy_d[grant_id] = 1'b0;
          rr_d               = grant_nxt;
          state_d            = IDLE;
        end
      end
      WRITE_RELAY: begin
        if (!bus.consumer_write_valid[grant_id]) begin
          wr_rdy_d[grant_id] = 1'b0;
          rr_d               = grant_nxt;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy                     = (state_q != IDLE);
  assign bus.mem_read_valid       = rd_vld_q;
  assign bus.mem_read_address     = rd_addr_q;
  assign bus.mem_write_valid      = wr_vld_q;
  assign bus.mem_write_address    = wr_addr_q;
  assign bus.mem_write_data       = wr_data_q;
  assign bus.consumer_read_ready  = rd_rdy_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_rdy_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: hand-computed expectations checked with immediate assertions.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  int         vectors = 0;
  int         miscompares = 0;

  lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.consumer_read_valid  = '0;
    bus.consumer_write_valid = '0;
    bus.mem_read_ready       = 1'b0;
    bus.mem_write_ready      = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = 1'b0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = 1'b0;
    repeat (2) tick();
    chk("rst_busy",    busy, 0);
    chk("rst_grant",   grant_id, 0);
    chk("rst_mrv",     bus.mem_read_valid, 0);
    chk("rst_mwv",     bus.mem_write_valid, 0);
    chk("rst_rrdy",    bus.consumer_read_ready, 0);
    chk("rst_wrdy",    bus.consumer_write_ready, 0);
    chk("rst_rdata",   bus.consumer_read_data, 0);
    rst_n = 1'b1;
    tick();

    // Single read from consumer 2, memory answers on the third WAIT cycle.
    bus.consumer_read_address[2*AB +: AB] = 8'h3C;
    bus.consumer_read_valid[2] = 1'b1;
    tick();
    chk("rd2_mrv_1cyc", bus.mem_read_valid, 1);
    chk("rd2_maddr",    bus.mem_read_address, 8'h3C);
    chk("rd2_grant",    grant_id, 2);
    chk("rd2_busy",     busy, 1);
    tick();
    tick();
    chk("rd2_mrv_hold", bus.mem_read_valid, 1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'hA5;
    tick();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = 8'h00;
    chk("rd2_rrdy",     bus.consumer_read_ready, 4'b0100);
    chk("rd2_rdata",    bus.consumer_read_data[2*DB +: DB], 8'hA5);
    chk("rd2_mrv_low",  bus.mem_read_valid, 0);
    tick();
    chk("rd2_rrdy_hold", bus.consumer_read_ready, 4'b0100);
    bus.consumer_read_valid[2] = 1'b0;
    tick();
    chk("rd2_rrdy_drop", bus.consumer_read_ready, 0);
    chk("rd2_idle",      busy, 0);

    // rr_ptr is now 3: consumer 3 wins over 1; reset mid-READ_WAIT returns the pointer to 0.
    bus.consumer_read_address[3*AB +: AB] = 8'h77;
    bus.consumer_read_address[1*AB +: AB] = 8'h11;
    bus.consumer_read_valid[3] = 1'b1;
    bus.consumer_read_valid[1] = 1'b1;
    tick();
    chk("rr3_grant", grant_id, 3);
    chk("rr3_mrv",   bus.mem_read_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mrv",   bus.mem_read_valid, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_maddr", bus.mem_read_address, 0);
    chk("arst_rdata", bus.consumer_read_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_grant", grant_id, 1);
    chk("post_rst_maddr", bus.mem_read_address, 8'h11);
    do_reset();

    // All four read continuously, each re-requests right after its relay.
    for (int i = 0; i < N; i++) bus.consumer_read_address[i*AB +: AB] = 8'h40 + 8'(i);
    bus.consumer_read_valid = 4'hF;
    tick();
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % N;
      chk("rr_grant", grant_id, g);
      chk("rr_maddr", bus.mem_read_address, 32'h40 + g);
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = 8'h90 + 8'(g);
      tick();
      bus.mem_read_ready = 1'b0;
      chk("rr_rrdy",  bus.consumer_read_ready, 32'h1 << g);
      chk("rr_rdata", bus.consumer_read_data[g*DB +: DB], 32'h90 + g);
      bus.consumer_read_valid[g] = 1'b0;
      tick();
      chk("rr_idle", busy, 0);
      bus.consumer_read_valid[g] = 1'b1;
      tick();
    end
    do_reset();

    // Consumer 1 read and write together: read first, spurious write-ready ignored.
    bus.consumer_read_address[1*AB +: AB]  = 8'h10;
    bus.consumer_write_address[1*AB +: AB] = 8'h20;
    bus.consumer_write_data[1*DB +: DB]    = 8'h7E;
    bus.consumer_read_valid[1]  = 1'b1;
    bus.consumer_write_valid[1] = 1'b1;
    tick();
    chk("rw_grant", grant_id, 1);
    chk("rw_mrv",   bus.mem_read_valid, 1);
    chk("rw_mwv",   bus.mem_write_valid, 0);
    chk("rw_maddr", bus.mem_read_address, 8'h10);
    bus.mem_write_ready = 1'b1;
    tick();
    bus.mem_write_ready = 1'b0;
    chk("spur_mrv",  bus.mem_read_valid, 1);
    chk("spur_busy", busy, 1);
    chk("spur_wrdy", bus.consumer_write_ready, 0);
    chk("spur_mwv",  bus.mem_write_valid, 0);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'h33;
    tick();
    bus.mem_read_ready = 1'b0;
    chk("rw_rrdy", bus.consumer_read_ready, 4'b0010);
    bus.consumer_read_valid[1] = 1'b0;
    tick();
    chk("rw_idle", busy, 0);
    tick();
    chk("wr_mwv",   bus.mem_write_valid, 1);
    chk("wr_maddr", bus.mem_write_address, 8'h20);
    chk("wr_mdata", bus.mem_write_data, 8'h7E);
    chk("wr_grant", grant_id, 1);
    bus.mem_write_ready = 1'b1;
    tick();
    bus.mem_write_ready = 1'b0;
    chk("wr_wrdy",    bus.consumer_write_ready, 4'b0010);
    chk("wr_mwv_low", bus.mem_write_valid, 0);
    bus.consumer_write_valid[1] = 1'b0;
    tick();
    chk("wr_wrdy_drop", bus.consumer_write_ready, 0);
    chk("wr_idle",      busy, 0);

    // Consumer 3 abandons its read during WAIT; ready still pulses once.
    bus.consumer_read_address[3*AB +: AB] = 8'h55;
    bus.consumer_read_valid[3] = 1'b1;
    tick();
    chk("drop_grant", grant_id, 3);
    bus.consumer_read_valid[3] = 1'b0;
    tick();
    chk("drop_mrv", bus.mem_read_valid, 1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'h5A;
    tick();
    bus.mem_read_ready = 1'b0;
    chk("drop_rrdy",  bus.consumer_read_ready, 4'b1000);
    chk("drop_rdata", bus.consumer_read_data[3*DB +: DB], 8'h5A);
    tick();
    chk("drop_pulse", bus.consumer_read_ready, 0);
    chk("drop_idle",  busy, 0);
    chk("data1_hold", bus.consumer_read_data[1*DB +: DB], 8'h33);
    bus.consumer_read_valid[0] = 1'b1;
    bus.consumer_read_valid[3] = 1'b1;
    tick();
    chk("wrap_grant", grant_id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel among NUM_CONSUMERS per-thread LSU request ports in a core.
- Uses round-robin arbitration. Only one transaction (read or write) is outstanding at a time.
- Consumer side uses the LSU valid/ready handshake. The ready signal stays asserted until the consumer drops valid.
- Sits between the core's LSU ports and the memory-side controller channel.

Parameters:
NUM_CONSUMERS, 4, number of LSU requesters (≥2)
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read complete, data valid
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed per-consumer read data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  1  downstream read request
mem_read_address  out  ADDR_BITS  downstream read address
mem_read_ready  in  1  downstream read done, mem_read_data valid this cycle
mem_read_data  in  DATA_BITS  downstream read data
mem_write_valid  out  1  downstream write request
mem_write_address  out  ADDR_BITS
mem_write_data  out  DATA_BITS
mem_write_ready  in  1  downstream write done
busy  out  1  high whenever state ≠ IDLE
grant_id  out  $clog2(NUM_CONSUMERS)  consumer currently owning the channel

Behaviour:

Reset (reset=0, asynchronous, also mid-transaction):
- state=IDLE, rr_ptr=0, grant_id=0.
- All valid/ready outputs are 0; all addr/data outputs are 0.
- Any in-flight transaction is abandoned.

States (3-bit): IDLE=0, READ_WAIT=1, WRITE_WAIT=2, READ_RELAY=3, WRITE_RELAY=4.

IDLE:
- Scan i = rr_ptr, rr_ptr+1, … (mod NUM_CONSUMERS). Select the first i with read_valid[i] | write_valid[i].
- If both are set for the same i, the read wins; the write is served on a later grant.
- On selection: grant_id←i; latch address (and write data); set mem_read_valid or mem_write_valid; go to READ_WAIT or WRITE_WAIT.
- Downstream valid is therefore high one cycle after the request is sampled.

READ_WAIT:
- Hold mem_read_valid and mem_read_address stable.
- On mem_read_ready: consumer_read_data[grant_id]←mem_read_data; mem_read_valid←0; consumer_read_ready[grant_id]←1; go to READ_RELAY.

WRITE_WAIT:
- Same as READ_WAIT, using mem_write_ready and consumer_write_ready.

READ_RELAY / WRITE_RELAY:
- Hold ready high while the consumer's valid is high.
- When the consumer's valid is 0: ready←0; rr_ptr←(grant_id+1) mod NUM_CONSUMERS; go to IDLE.
- Minimum occupancy per transaction: 1 (IDLE) + ≥1 (WAIT) + ≥1 (RELAY) cycles.

Boundary cases:
- Consumer drops valid during WAIT: the downstream transaction still completes; ready pulses for one cycle in RELAY.
- mem_*_ready while the corresponding mem_*_valid=0, or in the wrong state: ignored.
- consumer_read_data[i] holds its value until consumer i's next read completes.
- rr_ptr wraps from NUM_CONSUMERS-1 to 0.
- No starvation: with all consumers requesting continuously, each is granted once per NUM_CONSUMERS transactions.
- grant_id is meaningful only while busy=1.

Test Plan:
- Reset mid-READ_WAIT (mem_read_valid=1): drive reset=0 → all outputs 0, busy=0 immediately; after release, next request starts from consumer 0.
- Single read, consumer 2 addr 0x3C; memory returns 0xA5 after 3 cycles → mem_read_valid rises 1 cycle after request; consumer_read_ready[2]=1 with data 0xA5 one cycle after mem_read_ready; ready held until read_valid[2] drops.
- All 4 consumers read simultaneously and re-request immediately → grant order 0,1,2,3,0; each completes exactly once per round.
- Consumer 1 asserts read (0x10) and write (0x20, data 0x7E) together → read served first; write issued on a later grant with mem_write_address=0x20, mem_write_data=0x7E.
- Consumer 3 drops read_valid during READ_WAIT → downstream read still completes; consumer_read_ready[3] high for exactly 1 cycle; state returns to IDLE; rr_ptr=0.
- Spurious mem_write_ready during READ_WAIT → no state change; consumer_write_ready stays 0.
